equality_search_ctrl: RTL and testbench
=======================================

EQUALITY_SEARCH_CTRL -- requirements
Module: equality_search_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the number of 2-bit table entries (power of two, 2..16).
REQ-002 Parameter IDX_W, default 3, SHALL set the index width (log2 DEPTH).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 wr_en  input  1  SHALL request a table write.
REQ-006 wr_addr  input  IDX_W  SHALL give the table entry to write.
REQ-007 wr_data  input  2  SHALL give the 2-bit value to write.
REQ-008 start  input  1  SHALL request a search for key.
REQ-009 key  input  2  SHALL give the search key, sampled with start.
REQ-010 cmp_a  output  2  SHALL drive the A operand of the external equality comparator ({A_1,A_0}).
REQ-011 cmp_b  output  2  SHALL drive the B operand of the external equality comparator ({B_1,B_0}).
REQ-012 cmp_eq  input  1  SHALL carry the comparator OUT (1 = operands equal).
REQ-013 busy  output  1  SHALL be high while a search is in progress (states SCAN and DONE).
REQ-014 done  output  1  SHALL pulse high for exactly one cycle when a search completes.
REQ-015 found  output  1  SHALL indicate that the last completed search matched.
REQ-016 match_idx  output  IDX_W  SHALL give the lowest matching index of the last completed search.

Function
REQ-017 FSM states SHALL be IDLE, SCAN and DONE, held in a registered state.
REQ-018 IDLE: start=1 at an edge SHALL latch key into key_reg, clear idx to 0, clear found and match_idx, and move to SCAN.
REQ-019 SCAN: cmp_a SHALL equal key_reg and cmp_b SHALL equal table[idx], both combinational from registers.
REQ-020 SCAN, cmp_eq=1 at an edge: found SHALL become 1, match_idx SHALL become idx, and the next state SHALL be DONE.
REQ-021 SCAN, cmp_eq=0 at an edge with idx=DEPTH-1: found SHALL stay 0, match_idx SHALL stay 0, and the next state SHALL be DONE (no wrap-around).
REQ-022 SCAN, cmp_eq=0 at an edge with idx<DEPTH-1: idx SHALL increment by 1.
REQ-023 DONE: done SHALL be 1 for that cycle and the FSM SHALL return to IDLE at the next edge.
REQ-024 Latency: a match at index i SHALL make done high in the cycle after edge i+1, counting the start-sampling edge as edge 0; with no match, done SHALL be high after edge DEPTH.
REQ-025 found and match_idx SHALL hold their values from DONE until the next start is accepted.
REQ-026 In IDLE and DONE, cmp_a and cmp_b SHALL be 2'b00.
REQ-027 start SHALL be ignored while busy=1; a start held high SHALL launch a new search only from IDLE.
REQ-028 wr_en SHALL write table[wr_addr]=wr_data at the edge only when the state is IDLE; writes while busy=1 SHALL be dropped.
REQ-029 Simultaneous wr_en and start in IDLE: the write SHALL commit at that edge, and the search SHALL use the updated table.
REQ-030 Duplicate entries: the lowest matching index SHALL be reported.

Reset
REQ-031 rst=1 SHALL immediately force state=IDLE, idx=0, key_reg=0, all table entries=0, busy=0, done=0, found=0, match_idx=0, cmp_a=0 and cmp_b=0.
REQ-032 rst asserted mid-SCAN SHALL abort the search without a done pulse, and the block SHALL accept start on the first edge after rst deasserts.

Verification
REQ-033 Scenario 1: reset, then start with key=0 -> all entries are 0, so found=1, match_idx=0, and done appears after edge 1.
REQ-034 Scenario 2: write table = {0:1, 1:2, 2:3, 3:3, rest 0}, start key=3 -> found=1, match_idx=2 (lowest), and done after edge 3.
REQ-035 Scenario 3: table with no entry equal to 2, start key=2 -> found=0, match_idx=0, done after edge 8, and cmp_b steps through every entry.
REQ-036 Scenario 4: start held high for 20 cycles with a match at index 5 -> back-to-back searches, done pulses one cycle wide, and no start is accepted during SCAN or DONE.
REQ-037 Scenario 5: wr_en during SCAN targeting the index about to be compared -> the table is unchanged and the result reflects the old value.
REQ-038 Scenario 6: rst pulsed at idx=4 -> outputs go to 0 asynchronously, no done pulse, and the table reads all 0 on the next search.

Source files
------------

// File: rtl/equality_search_ctrl.sv
// Sequential lowest-index search of a small 2-bit table using an external
// equality comparator; one table entry is compared per clock.
module equality_search_ctrl #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [1:0]       wr_data,
  input  logic             start,
  input  logic [1:0]       key,
  output logic [1:0]       cmp_a,
  output logic [1:0]       cmp_b,
  input  logic             cmp_eq,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [IDX_W-1:0] match_idx
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [1:0]       key_reg;
  logic [1:0]       entries [DEPTH];

  // The comparator only sees real operands while scanning; otherwise it sees zeros.
  assign cmp_a = (state == SCAN) ? key_reg      : 2'b00;
  assign cmp_b = (state == SCAN) ? entries[idx] : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      key_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      found     <= 1'b0;
      match_idx <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= 2'b00;
      end
    end else begin
      // Writes land only while idle, so a search always sees a stable table.
      if (state == IDLE && wr_en) begin
        entries[wr_addr] <= wr_data;
      end

      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            key_reg   <= key;
            idx       <= '0;
            found     <= 1'b0;
            match_idx <= '0;
            busy      <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (cmp_eq) begin
            found     <= 1'b1;
            match_idx <= idx;
            done      <= 1'b1;
            state     <= DONE;
          end else if (idx == LAST_IDX) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_equality_search_ctrl.sv
// Self-checking bench for equality_search_ctrl: directed scenarios plus random
// tables, checked against a simple array-based reference of the search.
module tb_equality_search_ctrl;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [1:0]       wr_data;
  logic             start;
  logic [1:0]       key;
  logic [1:0]       cmp_a;
  logic [1:0]       cmp_b;
  logic             cmp_eq;
  logic             busy;
  logic             done;
  logic             found;
  logic [IDX_W-1:0] match_idx;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] model_tbl [DEPTH];

  always #5 clk = ~clk;

  // External equality comparator.
  assign cmp_eq = (cmp_a == cmp_b);

  equality_search_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .key(key), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_eq(cmp_eq),
    .busy(busy), .done(done), .found(found), .match_idx(match_idx)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [IDX_W-1:0] wa,
                               input logic [1:0] wd, input logic st,
                               input logic [1:0] k);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    start   = st;
    key     = k;
  endtask

  // Reference: first index holding the key, or -1.
  function automatic int ref_search(input logic [1:0] k);
    for (int i = 0; i < DEPTH; i++) begin
      if (model_tbl[i] == k) return i;
    end
    return -1;
  endfunction

  // Called just after a negedge with the DUT idle.
  task automatic write_entry(input int a, input logic [1:0] d);
    applyStimulus(1'b1, IDX_W'(a), d, 1'b0, 2'b00);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, '0, 2'b00, 1'b0, 2'b00);
    model_tbl[a] = d;
  endtask

  // One full search; optional write together with start, optional write
  // attempt during the scan (which must be dropped).
  task automatic run_search(input string tag, input logic [1:0] k,
                            input logic do_wr, input int wa, input logic [1:0] wd,
                            input int scan_wr_step, input int swa,
                            input logic [1:0] swd);
    int exp_i;
    int exp_edges;
    int edges;
    bit seen;
    logic prev_found;
    logic [IDX_W-1:0] prev_idx;
    applyStimulus(do_wr, IDX_W'(wa), wd, 1'b1, k);
    if (do_wr) model_tbl[wa] = wd;
    exp_i     = ref_search(k);
    exp_edges = (exp_i < 0) ? DEPTH : exp_i + 1;
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, '0, 2'b00, 1'b0, 2'b00);
    checkOutput({tag, ":busy_scan"}, 32'(busy), 32'd1);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < DEPTH + 3) begin
      if (edges < DEPTH) begin
        checkOutput({tag, ":cmp_a"}, 32'(cmp_a), 32'(k));
        checkOutput({tag, ":cmp_b"}, 32'(cmp_b), 32'(model_tbl[edges]));
      end
      if (edges == scan_wr_step) applyStimulus(1'b1, IDX_W'(swa), swd, 1'b0, 2'b00);
      @(posedge clk);
      @(negedge clk);
      applyStimulus(1'b0, '0, 2'b00, 1'b0, 2'b00);
      edges++;
      seen = done;
    end
    checkOutput({tag, ":done_seen"}, 32'(seen), 32'd1);
    checkOutput({tag, ":latency"}, 32'(edges), 32'(exp_edges));
    checkOutput({tag, ":found"}, 32'(found), (exp_i >= 0) ? 32'd1 : 32'd0);
    checkOutput({tag, ":match_idx"}, 32'(match_idx), (exp_i >= 0) ? 32'(exp_i) : 32'd0);
    checkOutput({tag, ":busy_done"}, 32'(busy), 32'd1);
    checkOutput({tag, ":cmp_a_done"}, 32'(cmp_a), 32'd0);
    checkOutput({tag, ":cmp_b_done"}, 32'(cmp_b), 32'd0);
    prev_found = found;
    prev_idx   = match_idx;
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, ":done_pulse"}, 32'(done), 32'd0);
    checkOutput({tag, ":busy_idle"}, 32'(busy), 32'd0);
    checkOutput({tag, ":found_hold"}, 32'(found), 32'(prev_found));
    checkOutput({tag, ":idx_hold"}, 32'(match_idx), 32'(prev_idx));
  endtask

  initial begin
    logic [1:0] k4;
    logic [1:0] rk;
    int waited;
    applyStimulus(1'b0, '0, 2'b00, 1'b0, 2'b00);
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) model_tbl[i] = 2'b00;
    repeat (2) @(negedge clk);
    checkOutput("rst:busy", 32'(busy), 32'd0);
    checkOutput("rst:done", 32'(done), 32'd0);
    checkOutput("rst:found", 32'(found), 32'd0);
    checkOutput("rst:match_idx", 32'(match_idx), 32'd0);
    checkOutput("rst:cmp_a", 32'(cmp_a), 32'd0);
    checkOutput("rst:cmp_b", 32'(cmp_b), 32'd0);
    rst = 1'b0;

    // Scenario 1: empty table, key 0 matches at index 0.
    run_search("s1", 2'd0, 1'b0, 0, 2'd0, -1, 0, 2'd0);

    // Scenario 2: duplicates, lowest index wins.
    write_entry(0, 2'd1);
    write_entry(1, 2'd2);
    write_entry(2, 2'd3);
    write_entry(3, 2'd3);
    run_search("s2", 2'd3, 1'b0, 0, 2'd0, -1, 0, 2'd0);

    // Scenario 3: no entry equals 2, full scan.
    write_entry(1, 2'd0);
    write_entry(4, 2'd0);
    write_entry(5, 2'd1);
    write_entry(6, 2'd3);
    write_entry(7, 2'd1);
    run_search("s3", 2'd2, 1'b0, 0, 2'd0, -1, 0, 2'd0);

    // Scenario 5: write during scan to the next index is dropped.
    run_search("s5", 2'd2, 1'b0, 0, 2'd0, 1, 2, 2'd2);
    run_search("s5b", 2'd2, 1'b0, 0, 2'd0, -1, 0, 2'd0);

    // Simultaneous write and start: search sees the new value.
    run_search("wr_start", 2'd2, 1'b1, 6, 2'd2, -1, 0, 2'd0);

    // Scenario 4: start held high, match at 5 -> period of 8 edges.
    k4 = 2'($urandom_range(0, 3));
    for (int i = 0; i < 5; i++) write_entry(i, 2'((k4 + 1 + $urandom_range(0, 2)) % 4));
    write_entry(5, k4);
    write_entry(6, 2'($urandom_range(0, 3)));
    write_entry(7, 2'($urandom_range(0, 3)));
    applyStimulus(1'b0, '0, 2'b00, 1'b1, k4);
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("s4:done", 32'(done), (n % 8 == 6) ? 32'd1 : 32'd0);
      checkOutput("s4:busy", 32'(busy), (n % 8 == 7) ? 32'd0 : 32'd1);
      if (n % 8 == 6) begin
        checkOutput("s4:found", 32'(found), 32'd1);
        checkOutput("s4:match_idx", 32'(match_idx), 32'd5);
      end
    end
    applyStimulus(1'b0, '0, 2'b00, 1'b0, 2'b00);
    waited = 0;
    while (busy && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("s4:drain", 32'(busy), 32'd0);

    // Random tables and keys.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DEPTH; i++) write_entry(i, 2'($urandom_range(0, 3)));
      rk = 2'($urandom_range(0, 3));
      run_search("rand", rk, 1'b0, 0, 2'd0, -1, 0, 2'd0);
    end

    // Scenario 6: reset in the middle of a scan at idx 4.
    for (int i = 0; i < DEPTH; i++) write_entry(i, 2'd1);
    applyStimulus(1'b0, '0, 2'b00, 1'b1, 2'd2);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, '0, 2'b00, 1'b0, 2'b00);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("s6:pre_cmp_b", 32'(cmp_b), 32'd1);
    checkOutput("s6:pre_busy", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("s6:busy", 32'(busy), 32'd0);
    checkOutput("s6:done", 32'(done), 32'd0);
    checkOutput("s6:found", 32'(found), 32'd0);
    checkOutput("s6:match_idx", 32'(match_idx), 32'd0);
    checkOutput("s6:cmp_a", 32'(cmp_a), 32'd0);
    checkOutput("s6:cmp_b", 32'(cmp_b), 32'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_tbl[i] = 2'b00;
    run_search("s6_after", 2'd3, 1'b0, 0, 2'd0, -1, 0, 2'd0);
    run_search("s6_zero", 2'd0, 1'b0, 0, 2'd0, -1, 0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
